// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types, sigma constants and helpers for the block finalize stage.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] matrix_t;

  typedef enum logic {
    FIN_IDLE,
    FIN_STREAM
  } fin_state_e;

  localparam word_t CHACHA_CONST0 = 32'h61707865;
  localparam word_t CHACHA_CONST1 = 32'h3320646e;
  localparam word_t CHACHA_CONST2 = 32'h79622d32;
  localparam word_t CHACHA_CONST3 = 32'h6b206574;

  // Matrices are packed high-first, so RFC word 0 sits at [3][3].
  function automatic word_t word_at(matrix_t m, int w);
    logic [1:0] r;
    logic [1:0] c;
    r = 2'(3 - (w >>> 2));
    c = 2'(3 - (w & 3));
    return m[r][c];
  endfunction

  function automatic word_t keep_mask(logic [3:0] keep);
    word_t m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

endpackage

// File: rtl/chacha_ct_skid.sv
// One-deep registered ciphertext output slice with full-throughput valid/ready.
module chacha_ct_skid
  import chacha_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_keep,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] ct_data,
  output logic [3:0]  ct_keep,
  output logic        ct_last,
  output logic        ct_valid,
  input  logic        ct_ready
);

  // A new word may replace the held one in the same cycle it is consumed.
  assign in_ready = !ct_valid || ct_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ct_data  <= '0;
      ct_keep  <= '0;
      ct_last  <= 1'b0;
      ct_valid <= 1'b0;
    end else if (load) begin
      ct_data  <= in_data;
      ct_keep  <= in_keep;
      ct_last  <= in_last;
      ct_valid <= 1'b1;
    end else if (ct_ready) begin
      ct_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha_block_finalize.sv
// ChaCha20 feed-forward addition, keystream buffer and plaintext XOR streamer.
module chacha_block_finalize
  import chacha_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int WIDX_W    = 4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        blockready,
  input  matrix_t     round_matrix,
  input  matrix_t     init_matrix,
  input  logic [31:0] pt_data,
  input  logic [3:0]  pt_keep,
  input  logic        pt_last,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [31:0] ct_data,
  output logic [3:0]  ct_keep,
  output logic        ct_last,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic        next_block_req,
  output logic        overrun
);

  fin_state_e state_q, state_d;
  logic [WIDX_W-1:0] idx_q;
  word_t [NUM_WORDS-1:0] ks_sum;
  word_t [NUM_WORDS-1:0] ks_q;
  logic  skid_ready;
  logic  accept;
  logic  block_end;
  word_t ct_word;

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_ff
    assign ks_sum[w] = word_at(round_matrix, w) + word_at(init_matrix, w);
  end

  assign pt_ready  = (state_q == FIN_STREAM) && skid_ready;
  assign accept    = pt_valid && pt_ready;
  assign block_end = accept && (pt_last || (idx_q == WIDX_W'(NUM_WORDS - 1)));
  assign ct_word   = (pt_data ^ ks_q[idx_q]) & keep_mask(pt_keep);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FIN_IDLE:   if (blockready) state_d = FIN_STREAM;
      FIN_STREAM: if (block_end)  state_d = FIN_IDLE;
      default:    state_d = FIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FIN_IDLE;
      idx_q          <= '0;
      next_block_req <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_block_req <= block_end;
      // The buffer is still in use until the FSM is back in IDLE.
      if (blockready && (state_q != FIN_IDLE)) overrun <= 1'b1;
      if (state_q == FIN_IDLE)
        idx_q <= '0;
      else if (accept)
        idx_q <= block_end ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == FIN_IDLE) && blockready) ks_q <= ks_sum;
  end

  chacha_ct_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .in_data  (ct_word),
    .in_keep  (pt_keep),
    .in_last  (pt_last),
    .in_ready (skid_ready),
    .ct_data  (ct_data),
    .ct_keep  (ct_keep),
    .ct_last  (ct_last),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready)
  );

endmodule

// File: doc/chacha_block_finalize.md
Name: chacha_block_finalize

Overview:
Downstream stage of PerformQround. On each blockready it captures the 20-round matrix (chachamatrixOUT) and the original input matrix. It performs the ChaCha20 feed-forward addition to form the 16-word keystream block. It then streams the keystream XORed with a 32-bit plaintext stream over valid/ready handshakes, and pulses a next-block request to the upstream state builder.

Parameters:
NUM_WORDS, 16, keystream words per block (fixed by ChaCha20; exists for readability only)
WIDX_W, 4, width of the word index counter

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
blockready  in  1  one-cycle pulse from PerformQround: round output is valid
round_matrix  in  word_t[3:0][3:0]  chachamatrixOUT from PerformQround
init_matrix  in  word_t[3:0][3:0]  same matrix that was presented as chachamatrixIN for this block
pt_data  in  32  plaintext word, byte 0 in [7:0]
pt_keep  in  4  byte enables, bit i qualifies byte i
pt_last  in  1  final word of message
pt_valid  in  1  plaintext handshake valid
pt_ready  out  1  plaintext handshake ready
ct_data  out  32  ciphertext word
ct_keep  out  4  copy of pt_keep
ct_last  out  1  copy of pt_last
ct_valid  out  1  ciphertext handshake valid
ct_ready  in  1  ciphertext handshake ready
next_block_req  out  1  one-cycle pulse: buffer freed, upstream may start the next block
overrun  out  1  sticky error flag: blockready seen while not in IDLE

Behaviour:
- Word mapping: RFC word w (0..15) is matrix[3-(w>>2)][3-(w&3)]. Word 0 (61707865) is [3][3]; word 12 (counter) is [0][3].
- Reset values: FSM=IDLE, word index=0, ct_valid=0, ct_data=0, ct_keep=0, ct_last=0, pt_ready=0, next_block_req=0, overrun=0. Buffer contents are don't-care.
- IDLE:
  - On blockready, the block computes ks[w] = round[w] + init[w] (mod 2^32, carry discarded) for all 16 words and registers them.
  - It then moves to STREAM, with index=0, one cycle after blockready.
- STREAM:
  - pt_ready = !ct_valid || ct_ready (one-deep registered output, full throughput).
  - On pt_valid && pt_ready:
    - ct_data <= (pt_data ^ ks[index]) with each byte whose keep bit is 0 forced to 0.
    - ct_keep/ct_last are copied from the input; ct_valid <= 1; index increments.
  - If no new beat is accepted and ct_ready=1, ct_valid <= 0.
- Block end:
  - Ends when a beat is accepted with index==15 (index wraps to 0) or with pt_last=1.
  - Either event moves the FSM to IDLE and pulses next_block_req for exactly one cycle, in the same cycle as the FSM update.
  - After pt_last, the unused keystream words are discarded.
- Draining in IDLE: pt_ready=0. ct_valid stays asserted until ct_ready, so the final beat drains normally.
- blockready outside IDLE: the event is ignored, the buffer is unchanged, and overrun <= 1. overrun clears only on rst.
- Simultaneous events: blockready in the same cycle as the final beat is accepted still counts as overrun, because the FSM is not yet IDLE.
- rst mid-stream: returns to reset values. Any pending ct beat is dropped, and no next_block_req is issued.
- ct_data, ct_keep and ct_last hold stable while ct_valid=1 && ct_ready=0.
- Latency: first ct_valid appears no earlier than 2 cycles after blockready, with pt_valid held high.

Decomposition:
- Shared package chacha_pkg holds:
  - word_t (logic[31:0]);
  - matrix_t (word_t[3:0][3:0]);
  - constants CHACHA_CONST0..3 (61707865, 3320646e, 79622d32, 6b206574);
  - function word_at(matrix_t, int w) implementing the mapping above.
- Optional sub-module chacha_ct_skid: the one-deep registered output slice with the valid/ready logic.
- The addition and FSM stay in the top module.

Test Plan:
1. Zero-round block:
   - Stimulus: round_matrix all 0, init_matrix = RFC 7539 2.3.2 input, pt_data=0, keep=F, ct_ready=1.
   - Response: ct words 0..3 = 61707865, 3320646e, 79622d32, 6b206574. next_block_req pulses after word 15.
2. RFC vector:
   - Stimulus: round_matrix = RFC 2.3.2 post-round state, init = the 2.3.2 input, pt=0.
   - Response: ct word 0 = e4e7f110, word 1 = 15593bd1, word 15 = 4e3c50a2.
3. Carry wrap:
   - Stimulus: round word 0 = ffffffff, init word 0 = 00000002, pt word = 0000ffff.
   - Response: ct_data = 0000fffe.
4. Backpressure:
   - Stimulus: ct_ready toggles 1/0 each cycle.
   - Response: ct_data held stable while stalled, 16 beats in order, no duplication or loss.
5. Partial block:
   - Stimulus: pt_last on word 5, keep=3.
   - Response: ct upper two bytes = 0, ct_last=1, FSM returns to IDLE, one next_block_req pulse.
6. Overrun and reset:
   - Stimulus: blockready during STREAM -> overrun=1 and output unaffected. Then rst at word 8.
   - Response: ct_valid=0, overrun=0, next_block_req never pulses.
